// File: rtl/rd_resp_mux.sv
// Read-response multiplexer between N bus slaves and the CPU load path.
// It latches the highest-priority selected slave at request time and waits
// for that slave's ready. It then returns one registered response with a
// single-cycle valid pulse. Unmapped reads and timeouts return DEFAULT_DATA
// with an error flag.
module rd_resp_mux #(
   parameter int                 N_SLV        = 5,
   parameter int                 DATA_W       = 32,
   parameter int                 TIMEOUT      = 16,
   parameter logic [DATA_W-1:0]  DEFAULT_DATA = {DATA_W{1'b0}},
   parameter bit                 UNMAP_ERR    = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      rd_req,
   input  logic [N_SLV-1:0]          cs_n,
   input  logic [N_SLV*DATA_W-1:0]   slv_rdata,
   input  logic [N_SLV-1:0]          slv_rdy,
   output logic                      req_ready,
   output logic                      busy,
   output logic                      rd_valid,
   output logic                      rd_err,
   output logic [DATA_W-1:0]         read_data,
   output logic                      sel_conflict
);

   localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [DATA_W-1:0]   data_d;
   logic                valid_d, err_d, conflict_d;

   logic [N_SLV-1:0]    cs_low;
   logic                any_sel, multi_sel;
   logic [SEL_W-1:0]    first_idx;
   logic                sel_rdy;
   logic [DATA_W-1:0]   sel_rdata;
   logic                tmo_hit;

   // Decode the chip selects: any/multiple selected, and the lowest low index wins
   always_comb begin
      cs_low    = ~cs_n;
      any_sel   = |cs_low;
      multi_sel = |(cs_low & (cs_low - N_SLV'(1)));
      first_idx = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (cs_low[i]) begin
            first_idx = SEL_W'(i);
         end
      end
   end

   // Pick out the latched slave's ready and data; the timeout fires on the last allowed WAIT cycle
   always_comb begin
      sel_rdy   = slv_rdy[sel_q];
      sel_rdata = slv_rdata[int'(sel_q) * DATA_W +: DATA_W];
      tmo_hit   = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));
   end

   // Next-state and next-response logic; ready takes precedence over an expiring timer
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      timer_d    = timer_q;
      data_d     = read_data;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      conflict_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_req) begin
               if (any_sel) begin
                  sel_d      = first_idx;
                  timer_d    = '0;
                  conflict_d = multi_sel;
                  state_d    = WAIT;
               end else begin
                  valid_d = 1'b1;
                  data_d  = DEFAULT_DATA;
                  err_d   = UNMAP_ERR;
               end
            end
         end
         WAIT: begin
            if (sel_rdy) begin
               valid_d = 1'b1;
               data_d  = sel_rdata;
               state_d = IDLE;
            end else if (tmo_hit) begin
               valid_d = 1'b1;
               data_d  = DEFAULT_DATA;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, selection, timer and registered response outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         timer_q      <= '0;
         read_data    <= '0;
         rd_valid     <= 1'b0;
         rd_err       <= 1'b0;
         sel_conflict <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         timer_q      <= timer_d;
         read_data    <= data_d;
         rd_valid     <= valid_d;
         rd_err       <= err_d;
         sel_conflict <= conflict_d;
      end
   end

   // Handshake outputs decode the state directly
   always_comb begin
      busy      = (state_q == WAIT);
      req_ready = (state_q == IDLE);
   end

endmodule
